// File: rtl/sync_fifo_flags_pkg.sv
// sync_fifo_flags_pkg: sizing helpers shared by the flagged single-clock FIFO
package sync_fifo_flags_pkg;
   function automatic int cnt_bits(input int depth);
      return $clog2(depth + 1);
   endfunction
   function automatic int ptr_bits(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/sync_fifo_flags_ram.sv
// sync_fifo_flags_ram: simple dual-port storage array, registered or combinational read
module sync_fifo_flags_ram #(
   parameter int DEPTH  = 10,
   parameter int WIDTH  = 4,
   parameter int AW     = 4,
   parameter int REG_RD = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   if (REG_RD != 0) begin : g_reg
      always_ff @(posedge clk or posedge rst)
         if (rst) rdata <= '0;
         else if (re) rdata <= mem[raddr];
   end else begin : g_comb
      logic unused_rd;
      assign unused_rd = rst ^ re;
      assign rdata = mem[raddr];
   end
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with fill count, almost flags and optional FWFT read
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module sync_fifo_flags
   import sync_fifo_flags_pkg::*;
#(
   parameter int DEPTH     = 10,
   parameter int WIDTH     = 4,
   parameter int AFULL_TH  = 8,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0,
   localparam int CNT_W    = cnt_bits(DEPTH),
   localparam int PTR_W    = ptr_bits(DEPTH)
) (
   input  logic             clk,
   input  logic             asrst,
   input  logic             wren,
   input  logic [WIDTH-1:0] wrdata,
   output logic             full,
   output logic             almost_full,
   input  logic             rden,
   output logic [WIDTH-1:0] rddata,
   output logic             rdvalid,
   output logic             empty,
   output logic             almost_empty,
`ifdef SYNC_FIFO_ERR_EN
   input  logic             err_clr,
   output logic             err_ovf,
   output logic             err_unf,
`endif
   output logic [CNT_W-1:0] count
);
   if (DEPTH < 2 || AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad
      $error("sync_fifo_flags: illegal DEPTH/threshold parameters");
   end
   logic             rd_acc, wr_acc;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic [WIDTH-1:0] ram_q;
   // A full FIFO still takes a write when a read frees a slot on the same edge.
   assign rd_acc    = rden & ~empty;
   assign wr_acc    = wren & (~full | rd_acc);
   assign count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   always_ff @(posedge clk or posedge asrst)
      if (asrst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= inc(wr_ptr);
         if (rd_acc) rd_ptr <= inc(rd_ptr);
         count        <= count_nxt;
         empty        <= count_nxt == '0;
         full         <= count_nxt == CNT_W'(DEPTH);
         almost_full  <= count_nxt >= CNT_W'(AFULL_TH);
         almost_empty <= count_nxt <= CNT_W'(AEMPTY_TH);
      end
   sync_fifo_flags_ram #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(PTR_W), .REG_RD(FWFT == 0 ? 1 : 0)
   ) u_ram (
      .clk(clk), .rst(asrst),
      .we(wr_acc), .waddr(wr_ptr), .wdata(wrdata),
      .re(rd_acc), .raddr(rd_ptr), .rdata(ram_q)
   );
   if (FWFT != 0) begin : g_fwft
      assign rddata  = empty ? '0 : ram_q;
      assign rdvalid = ~empty;
   end else begin : g_std
      assign rddata = ram_q;
      always_ff @(posedge clk or posedge asrst)
         if (asrst) rdvalid <= 1'b0;
         else rdvalid <= rd_acc;
   end
`ifdef SYNC_FIFO_ERR_EN
   // Set beats clear when both happen in the same cycle.
   always_ff @(posedge clk or posedge asrst)
      if (asrst) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         err_ovf <= (wren & ~wr_acc) | (err_ovf & ~err_clr);
         err_unf <= (rden & empty) | (err_unf & ~err_clr);
      end
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: scoreboard bench, queue reference model plus a directed FWFT instance
module tb_sync_fifo_flags;
   localparam int DEPTH = 10;
   localparam int AF    = 8;
   localparam int AE    = 2;
   logic       clk = 0, asrst = 1;
   logic       wren = 0, rden = 0;
   logic [3:0] wrdata = 0;
   logic       full, almost_full, rdvalid, empty, almost_empty;
   logic [3:0] rddata, count;
   logic       f_wren = 0, f_rden = 0;
   logic [3:0] f_wrdata = 0, f_rddata, f_count;
   logic       f_full, f_almost_full, f_rdvalid, f_empty, f_almost_empty;
`ifdef SYNC_FIFO_ERR_EN
   logic       err_clr = 0, err_ovf, err_unf, f_err_ovf, f_err_unf;
   bit         ovf_m, unf_m;
`endif
   int         checks = 0, failures = 0;
   int         m_q[$], exp_q[$];
   bit         rv_m;
   always #5 clk = ~clk;
   sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(4), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) dut (
      .clk(clk), .asrst(asrst), .wren(wren), .wrdata(wrdata), .full(full),
      .almost_full(almost_full), .rden(rden), .rddata(rddata), .rdvalid(rdvalid),
      .empty(empty), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_EN
      .err_clr(err_clr), .err_ovf(err_ovf), .err_unf(err_unf),
`endif
      .count(count));
   sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(4), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) dut_f (
      .clk(clk), .asrst(asrst), .wren(f_wren), .wrdata(f_wrdata), .full(f_full),
      .almost_full(f_almost_full), .rden(f_rden), .rddata(f_rddata), .rdvalid(f_rdvalid),
      .empty(f_empty), .almost_empty(f_almost_empty),
`ifdef SYNC_FIFO_ERR_EN
      .err_clr(1'b0), .err_ovf(f_err_ovf), .err_unf(f_err_unf),
`endif
      .count(f_count));
   function automatic void chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: act=%0d exp=%0d", n, act, exp);
      end
   endfunction
   // Scoreboard monitor: every rdvalid pulse must deliver the oldest expected word.
   always @(negedge clk)
      if (!asrst && rdvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rddata: rdvalid with nothing expected, act=%0d", rddata);
         end else chk("rddata", int'(rddata), exp_q.pop_front());
      end
   task automatic check_state(input string t);
      int n;
      n = m_q.size();
      chk({t, " count"}, int'(count), n);
      chk({t, " full"}, int'(full), int'(n == DEPTH));
      chk({t, " empty"}, int'(empty), int'(n == 0));
      chk({t, " almost_full"}, int'(almost_full), int'(n >= AF));
      chk({t, " almost_empty"}, int'(almost_empty), int'(n <= AE));
      chk({t, " rdvalid"}, int'(rdvalid), int'(rv_m));
`ifdef SYNC_FIFO_ERR_EN
      chk({t, " err_ovf"}, int'(err_ovf), int'(ovf_m));
      chk({t, " err_unf"}, int'(err_unf), int'(unf_m));
`endif
   endtask
   task automatic check_reset(input string t);
      chk({t, " count"}, int'(count), 0);
      chk({t, " empty"}, int'(empty), 1);
      chk({t, " almost_empty"}, int'(almost_empty), 1);
      chk({t, " full"}, int'(full), 0);
      chk({t, " almost_full"}, int'(almost_full), 0);
      chk({t, " rdvalid"}, int'(rdvalid), 0);
      chk({t, " rddata"}, int'(rddata), 0);
`ifdef SYNC_FIFO_ERR_EN
      chk({t, " err_ovf"}, int'(err_ovf), 0);
      chk({t, " err_unf"}, int'(err_unf), 0);
`endif
   endtask
   // One clock of stimulus issued at a falling edge; the model decides acceptance up front.
   task automatic step(input string t, input bit w, input logic [3:0] d, input bit r, input bit clr);
      bit ra, wa;
      ra = r && m_q.size() > 0;
      wa = w && (m_q.size() < DEPTH || ra);
`ifdef SYNC_FIFO_ERR_EN
      ovf_m   = (w && !wa) || (ovf_m && !clr);
      unf_m   = (r && m_q.size() == 0) || (unf_m && !clr);
      err_clr = clr;
`else
      if (clr) ra = ra;
`endif
      wren = w; wrdata = d; rden = r;
      if (ra) exp_q.push_back(m_q.pop_front());
      if (wa) m_q.push_back(int'(d));
      rv_m = ra;
      @(negedge clk);
      wren = 0; rden = 0;
`ifdef SYNC_FIFO_ERR_EN
      err_clr = 0;
`endif
      check_state(t);
   endtask
   initial begin
      int bias;
      repeat (2) @(negedge clk);
      check_reset("reset");
      asrst = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) step("fill", 1, 4'(i), 0, 0);
      step("overflow", 1, 4'hF, 0, 0);
      for (int i = 0; i < 12; i++) step("drain", 0, 4'h0, 1, 0);
      step("err_clr", 0, 4'h0, 0, 1);
      for (int i = 0; i < 10; i++) step("wrap fill", 1, 4'(i), 0, 0);
      for (int i = 0; i < 5; i++) step("wrap read", 0, 4'h0, 1, 0);
      for (int i = 0; i < 5; i++) step("wrap rdwr", 1, 4'(10 + i), 1, 0);
      for (int i = 0; i < 5; i++) step("refill", 1, 4'(i + 1), 0, 0);
      for (int i = 0; i < 3; i++) step("full rdwr", 1, 4'(12 + i), 1, 0);
      for (int p = 0; p < 6; p++) begin
         bias = (p % 2 == 0) ? 75 : 25;
         for (int i = 0; i < 100; i++)
            step("random", $urandom_range(0, 99) < bias, 4'($urandom),
                 $urandom_range(0, 99) < 100 - bias, $urandom_range(0, 15) == 0);
      end
      while (m_q.size() > 0) step("flush", 0, 4'h0, 1, 0);
      step("flush clr", 0, 4'h0, 0, 1);
      for (int i = 0; i < 6; i++) step("pre reset", 1, 4'(9 - i), 0, 0);
      step("pre reset rd", 0, 4'h0, 1, 0);
      step("pre reset wr", 1, 4'hA, 0, 0);
      #2 asrst = 1;
      #1 check_reset("async reset");
      m_q.delete();
      exp_q.delete();
      rv_m = 0;
`ifdef SYNC_FIFO_ERR_EN
      ovf_m = 0;
      unf_m = 0;
`endif
      @(negedge clk);
      asrst = 0;
      step("post reset wr", 1, 4'h7, 0, 0);
      step("post reset rd", 0, 4'h0, 1, 0);
      step("post reset idle", 0, 4'h0, 0, 0);
      chk("fwft reset empty", int'(f_empty), 1);
      chk("fwft reset rdvalid", int'(f_rdvalid), 0);
      f_wren = 1; f_wrdata = 4'h3;
      @(negedge clk);
      f_wren = 0;
      chk("fwft write empty", int'(f_empty), 0);
      chk("fwft write rdvalid", int'(f_rdvalid), 1);
      chk("fwft write rddata", int'(f_rddata), 3);
      chk("fwft write count", int'(f_count), 1);
      @(negedge clk);
      chk("fwft hold rddata", int'(f_rddata), 3);
      f_wren = 1; f_wrdata = 4'h5; f_rden = 1;
      @(negedge clk);
      f_wren = 0; f_rden = 0;
      chk("fwft rdwr rddata", int'(f_rddata), 5);
      chk("fwft rdwr count", int'(f_count), 1);
      f_rden = 1;
      @(negedge clk);
      f_rden = 0;
      chk("fwft pop empty", int'(f_empty), 1);
      chk("fwft pop rdvalid", int'(f_rdvalid), 0);
      chk("fwft pop count", int'(f_count), 0);
      @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
